data_array_ctrl: RTL and testbench

Initiator-side controller for the 128 x 256-bit single-port data-array SRAM macro (active-low chip select and write enable, byte write mask, inputs sampled on clk0 rising edge, read data valid before the next rising edge). It sits between the cache datapath and the macro. It accepts read/write requests over a valid/ready handshake and drives the macro port. It captures read data into a one-entry response register with backpressure, and zero-fills the whole array after reset.

---
 rtl/data_array_ctrl.sv | 106 ++++++++++
 tb/tb_data_array_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_array_ctrl.sv
// Initiator-side controller for the 128 x 256-bit single-port data-array SRAM.
// Valid/ready request port, one-entry read response register, zero-fill after reset.
module data_array_ctrl #(
    parameter int DATA_WIDTH    = 256,
    parameter int ADDR_WIDTH    = 7,
    parameter int NUM_WMASKS    = 32,
    parameter bit INIT_ON_RESET = 1'b1
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    typedef enum logic {INIT, RUN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  rd_pend;
    logic                  fire;

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) state_q <= INIT;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && (!INIT_ON_RESET || init_cnt == '1))
            state_d = RUN;
    end

    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0)
            init_cnt <= '0;
        else if (state_q == INIT && INIT_ON_RESET)
            init_cnt <= init_cnt + 1'b1;
    end

    assign init_done = (state_q == RUN);

    // Reads and writes share one ready rule so requests never reorder.
    always_comb begin
        req_ready = 1'b0;
        if (!rst0 && state_q == RUN)
            req_ready = !resp_valid || resp_ready;
    end

    assign fire = req_valid && req_ready;

    always_comb begin
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_addr0  = req_addr;
        sram_wmask0 = req_wmask;
        sram_din0   = req_wdata;
        if (rst0) begin
            sram_addr0  = '0;
            sram_wmask0 = '0;
            sram_din0   = '0;
        end else if (state_q == INIT) begin
            if (INIT_ON_RESET) begin
                sram_csb0   = 1'b0;
                sram_web0   = 1'b0;
                sram_addr0  = init_cnt;
                sram_wmask0 = '1;
                sram_din0   = '0;
            end
        end else if (fire) begin
            sram_csb0 = 1'b0;
            sram_web0 = !req_write;
        end
    end

    // Macro output is only valid at the edge right after the read; capture there.
    always_ff @(posedge clk0 or posedge rst0) begin
        if (rst0) begin
            rd_pend    <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            rd_pend <= fire && !req_write;
            if (rd_pend) begin
                resp_valid <= 1'b1;
                resp_rdata <= sram_dout0;
            end else if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_array_ctrl.sv
// Randomized bench for data_array_ctrl: SRAM macro model plus a line-level
// scoreboard predicting handshake, macro drive and read responses.
module tb_data_array_ctrl;

    logic         clk0 = 1'b0;
    logic         rst0;
    logic         req_valid, req_write, resp_ready;
    logic [6:0]   req_addr;
    logic [255:0] req_wdata;
    logic [31:0]  req_wmask;
    logic         req_ready, resp_valid, init_done;
    logic [255:0] resp_rdata;
    logic         sram_csb0, sram_web0;
    logic [6:0]   sram_addr0;
    logic [31:0]  sram_wmask0;
    logic [255:0] sram_din0, sram_dout0;

    // second instance with zero-fill disabled, never given requests
    logic         d2_req_valid = 1'b0, d2_req_write = 1'b0, d2_resp_ready = 1'b1;
    logic [6:0]   d2_req_addr = '0;
    logic [255:0] d2_req_wdata = '0, d2_dout = '0;
    logic [31:0]  d2_req_wmask = '0;
    logic         d2_req_ready, d2_resp_valid, d2_init_done, d2_csb0, d2_web0;
    logic [255:0] d2_resp_rdata, d2_din0;
    logic [6:0]   d2_addr0;
    logic [31:0]  d2_wmask0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk0 = ~clk0;

    data_array_ctrl dut (
        .clk0(clk0), .rst0(rst0),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .init_done(init_done),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
        .sram_wmask0(sram_wmask0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    data_array_ctrl #(.INIT_ON_RESET(1'b0)) dut2 (
        .clk0(clk0), .rst0(rst0),
        .req_valid(d2_req_valid), .req_ready(d2_req_ready), .req_write(d2_req_write),
        .req_addr(d2_req_addr), .req_wdata(d2_req_wdata), .req_wmask(d2_req_wmask),
        .resp_valid(d2_resp_valid), .resp_ready(d2_resp_ready), .resp_rdata(d2_resp_rdata),
        .init_done(d2_init_done),
        .sram_csb0(d2_csb0), .sram_web0(d2_web0), .sram_addr0(d2_addr0),
        .sram_wmask0(d2_wmask0), .sram_din0(d2_din0), .sram_dout0(d2_dout)
    );

    // SRAM macro: inputs sampled on the rising edge, read data valid by the next edge
    logic [255:0] smem [128];
    always @(posedge clk0) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < 32; b++)
                    if (sram_wmask0[b]) smem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
            end else begin
                sram_dout0 <= smem[sram_addr0];
            end
        end
    end

    // reference model state
    logic [255:0] ref_mem [128];
    logic         m_run, m_valid, m_pend;
    logic [255:0] m_data, m_pend_data;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] d,
                                           input logic [31:0] m);
        logic [255:0] r;
        r = old;
        for (int b = 0; b < 32; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // One clock: drive at negedge, check combinational drive, advance model at posedge,
    // check registered response at the following negedge.
    task automatic step(input logic v, input logic w, input logic [6:0] a,
                        input logic [255:0] d, input logic [31:0] m, input logic rr);
        logic er, f;
        req_valid = v; req_write = w; req_addr = a;
        req_wdata = d; req_wmask = m; resp_ready = rr;
        #1;
        er = m_run && (!m_valid || rr);
        f  = v && er;
        chk("req_ready", req_ready, er);
        chk("csb0", sram_csb0, !f);
        if (f) begin
            chk("web0", sram_web0, !w);
            chk("addr0", sram_addr0, a);
            chk("din0", sram_din0, d);
            chk("wmask0", sram_wmask0, m);
        end
        @(posedge clk0);
        if (m_pend) begin
            m_valid = 1'b1;
            m_data  = m_pend_data;
        end else if (m_valid && rr) begin
            m_valid = 1'b0;
        end
        m_pend = f && !w;
        if (f && !w) m_pend_data = ref_mem[a];
        if (f && w)  ref_mem[a] = merge(ref_mem[a], d, m);
        @(negedge clk0);
        chk("resp_valid", resp_valid, m_valid);
        if (m_valid) chk("resp_rdata", resp_rdata, m_data);
    endtask

    task automatic rd(input logic [6:0] a, input logic rr);
        step(1'b1, 1'b0, a, rand256(), $urandom, rr);
    endtask

    task automatic wr(input logic [6:0] a, input logic [255:0] d, input logic [31:0] m);
        step(1'b1, 1'b1, a, d, m, 1'b1);
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 1'b0, 7'd0, '0, '0, rr);
    endtask

    // Called at the negedge right after reset release; requests held up to prove they are ignored.
    task automatic do_init();
        m_run = 1'b0; m_valid = 1'b0; m_pend = 1'b0;
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
        req_valid = 1'b1; req_write = 1'b1; resp_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            #1;
            chk("init_done_low", init_done, 1'b0);
            chk("init_req_ready", req_ready, 1'b0);
            chk("init_csb0", sram_csb0, 1'b0);
            chk("init_web0", sram_web0, 1'b0);
            chk("init_addr0", sram_addr0, i[6:0]);
            chk("init_wmask0", sram_wmask0, 32'hFFFF_FFFF);
            chk("init_din0", sram_din0, 256'd0);
            chk("noinit_csb0", d2_csb0, 1'b1);
            chk("noinit_done", d2_init_done, (i > 0));
            @(posedge clk0);
            @(negedge clk0);
        end
        chk("init_done_high", init_done, 1'b1);
        m_run = 1'b1;
    endtask

    initial begin
        logic [255:0] a5, exp5;
        for (int i = 0; i < 128; i++) smem[i] = rand256();
        sram_dout0 = '0;
        rst0 = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h55;
        req_wdata = rand256(); req_wmask = '1; resp_ready = 1'b1;
        @(negedge clk0);
        @(negedge clk0);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_rdata", resp_rdata, 256'd0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_csb0", sram_csb0, 1'b1);
        chk("rst_web0", sram_web0, 1'b1);
        chk("rst_addr0", sram_addr0, 7'd0);
        chk("rst_wmask0", sram_wmask0, 32'd0);
        chk("rst_din0", sram_din0, 256'd0);
        chk("rst_noinit_done", d2_init_done, 1'b0);
        rst0 = 1'b0;
        do_init();

        // zero-fill visible through reads
        rd(7'd0, 1'b1); rd(7'd64, 1'b1); rd(7'd127, 1'b1); idle(1'b1);

        // full write then partial byte write over it
        a5 = {32{8'hA5}};
        wr(7'd5, a5, 32'hFFFF_FFFF);
        rd(7'd5, 1'b1);
        wr(7'd5, {224'd0, 32'h1122_3344}, 32'h0000_000F);
        rd(7'd5, 1'b1);
        idle(1'b1);
        exp5 = {a5[255:32], 32'h1122_3344};
        chk("partial_write_line", ref_mem[5], exp5);
        wr(7'd5, rand256(), 32'd0);
        rd(7'd5, 1'b1); idle(1'b1);

        // back-to-back reads
        for (int i = 1; i <= 3; i++) wr(i[6:0], rand256(), 32'hFFFF_FFFF);
        rd(7'd1, 1'b1); rd(7'd2, 1'b1); rd(7'd3, 1'b1); idle(1'b1); idle(1'b1);

        // backpressure: held response, requests stalled, then release fires same cycle
        rd(7'd7, 1'b1);
        idle(1'b0);
        for (int i = 0; i < 5; i++) rd(7'd8, 1'b0);
        rd(7'd8, 1'b1);
        idle(1'b1); idle(1'b1);

        // randomized traffic over a small address window to force reuse
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 7'($urandom_range(0, 15)), rand256(), $urandom,
                 ($urandom_range(0, 9) < 7));
        for (int i = 0; i < 3; i++) idle(1'b1);

        // asynchronous reset with a held response and a read in flight
        rd(7'd9, 1'b1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 7'd10; resp_ready = 1'b1;
        @(posedge clk0);
        #1;
        chk("pre_rst_resp_valid", resp_valid, 1'b1);
        #1;
        rst0 = 1'b1;
        #1;
        chk("async_rst_resp_valid", resp_valid, 1'b0);
        chk("async_rst_rdata", resp_rdata, 256'd0);
        chk("async_rst_csb0", sram_csb0, 1'b1);
        chk("async_rst_req_ready", req_ready, 1'b0);
        @(negedge clk0);
        @(negedge clk0);
        rst0 = 1'b0;
        do_init();
        for (int i = 0; i < 128; i++) rd(i[6:0], 1'b1);
        idle(1'b1); idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
